jt1943_dwnld: RTL and testbench

Byte-stream ROM download sequencer between the HPS `ioctl` download port and the SDRAM programming port and PROM write strobes of the 1943 core. It buffers incoming bytes in a 4-entry FIFO, applies backpressure through `ioctl_wait`, and converts each byte into either:

- an SDRAM byte-lane write with a `prog_we`/`prog_ack` handshake, or
- a one-cycle PROM write strobe.

It signals completion once the last byte has been committed.

---
 rtl/jt1943_dwnld.sv | 136 +++++++++++++
 tb/tb_jt1943_dwnld.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_dwnld.sv
// ROM download sequencer: buffers ioctl bytes in a 4-deep FIFO and commits each
// one either as an SDRAM byte-lane write (prog_we/prog_ack) or as a PROM strobe.
module jt1943_dwnld #(
  parameter logic [21:0] PROM_START = 22'h1E0000,
  parameter int          PROM_N     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic              ioctl_wr,
  input  logic [21:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  output logic              prog_we,
  output logic [21:0]       prog_addr,
  output logic [7:0]        prog_data,
  output logic [1:0]        prog_mask,
  input  logic              prog_ack,
  output logic [PROM_N-1:0] prom_we,
  output logic [7:0]        prom_addr,
  output logic [7:0]        prom_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  localparam logic [1:0]  IDLE = 2'd0, SDWR = 2'd1, GAP = 2'd2;
  localparam logic [21:0] PROM_SPAN = 22'(PROM_N * 256);

  logic [29:0]       mem_q [4];
  logic [1:0]        wp_q, rp_q, state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              push, pop, sd_load, prom_pop, prom_fire, hold_q;
  logic              dl_q, fall, rise, arm_q, arm_d, done_fire, ovf_q, ovf_d;
  logic              prog_we_q, busy_q, done_q;
  logic [21:0]       prog_addr_q, head_addr;
  logic [7:0]        prog_data_q, prom_addr_q, prom_data_q, head_data;
  logic [1:0]        prog_mask_q;
  logic [PROM_N-1:0] prom_we_q, oh;
  logic [2:0]        idx;
  logic              is_prom, hit;

  assign push       = ioctl_wr && !cnt_q[2];
  assign {head_addr, head_data} = mem_q[rp_q];
  assign is_prom    = head_addr >= PROM_START;
  // Range check covers the whole offset so bytes past the last PROM are dropped
  assign hit        = (head_addr - PROM_START) < PROM_SPAN;
  assign idx        = 3'((head_addr - PROM_START) >> 8);
  assign ioctl_wait = cnt_q >= 3'd3;
  assign fall       = dl_q && !downloading;
  assign rise       = !dl_q && downloading;
  assign done_fire  = (arm_q || fall) && cnt_q == 3'd0 && state_q == IDLE;

  always_comb begin
    oh = '0;
    for (int i = 0; i < PROM_N; i++) oh[i] = (idx == 3'(i));
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    sd_load   = 1'b0;
    prom_pop  = 1'b0;
    prom_fire = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != 3'd0 && !hold_q) begin
        if (!is_prom) begin
          sd_load = 1'b1;
          state_d = SDWR;
        end else begin
          pop       = 1'b1;
          prom_pop  = 1'b1;
          prom_fire = hit;
        end
      end
      SDWR: if (prog_ack) begin
        pop     = 1'b1;
        state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
    arm_d = done_fire ? 1'b0 : (fall ? 1'b1 : arm_q);
    ovf_d = (ioctl_wr && cnt_q[2]) ? 1'b1 : (rise ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {ioctl_addr, ioctl_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0; rp_q <= '0; cnt_q <= '0; state_q <= IDLE; hold_q <= 1'b0;
      dl_q <= 1'b0; arm_q <= 1'b0; ovf_q <= 1'b0; done_q <= 1'b0; busy_q <= 1'b0;
      prog_we_q <= 1'b0; prog_addr_q <= '0; prog_data_q <= '0; prog_mask_q <= '0;
      prom_we_q <= '0; prom_addr_q <= '0; prom_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wp_q <= wp_q + 2'd1;
      if (pop)  rp_q <= rp_q + 2'd1;
      // PROM path rests one cycle after each byte, giving one strobe per 2 cycles
      hold_q    <= prom_pop;
      dl_q      <= downloading;
      arm_q     <= arm_d;
      ovf_q     <= ovf_d;
      done_q    <= done_fire;
      busy_q    <= (cnt_q != 3'd0) || (state_q != IDLE);
      prog_we_q <= (state_d == SDWR);
      if (sd_load) begin
        prog_addr_q <= {1'b0, head_addr[21:1]};
        prog_data_q <= head_data;
        prog_mask_q <= head_addr[0] ? 2'b01 : 2'b10;
      end
      prom_we_q <= prom_fire ? oh : '0;
      if (prom_fire) begin
        prom_addr_q <= head_addr[7:0];
        prom_data_q <= head_data;
      end
    end
  end

  assign prog_we   = prog_we_q;
  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign prog_mask = prog_mask_q;
  assign prom_we   = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_jt1943_dwnld.sv
// Bench for jt1943_dwnld: directed scenarios with literal checks plus random
// traffic compared every cycle against a queue-based reference model.
module tb_jt1943_dwnld;
  localparam logic [21:0] START = 22'h1E0000;
  localparam int          PN    = 8;

  logic clk, rst_n, downloading, ioctl_wr, ioctl_wait, prog_we, prog_ack;
  logic busy, done, ovf;
  logic [21:0] ioctl_addr, prog_addr;
  logic [7:0]  ioctl_data, prog_data, prom_addr, prom_data;
  logic [1:0]  prog_mask;
  logic [PN-1:0] prom_we;

  jt1943_dwnld #(.PROM_START(START), .PROM_N(PN)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ack(prog_ack), .prom_we(prom_we),
    .prom_addr(prom_addr), .prom_data(prom_data), .busy(busy), .done(done), .ovf(ovf));

  int total = 0, bad = 0, cyc = 0;
  int ack_mode = 0;
  bit chk_en = 0;
  int sd_commits = 0, done_cnt = 0, done_cyc = 0, last_ack_cyc = 0;
  logic done_prev = 0, busy_post = 1;

  // reference model state
  logic [29:0] m_q[$];
  bit m_wr, m_rest_sd, m_rest_pr, m_armed, m_dl;
  logic e_prog_we, e_busy, e_done, e_ovf;
  logic [21:0] e_prog_addr;
  logic [7:0]  e_prog_data, e_prom_addr, e_prom_data;
  logic [1:0]  e_prog_mask;
  logic [PN-1:0] e_prom_we;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #400000; $display("FAIL watchdog act=timeout exp=finish"); $fatal(1); end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wr = 0; m_rest_sd = 0; m_rest_pr = 0; m_armed = 0; m_dl = 0;
    e_prog_we = 0; e_busy = 0; e_done = 0; e_ovf = 0;
    e_prog_addr = 0; e_prog_data = 0; e_prog_mask = 0;
    e_prom_we = 0; e_prom_addr = 0; e_prom_data = 0;
  endtask

  task automatic model_step();
    int sz;
    bit idle_old, fall, rise, pop;
    logic [29:0] h;
    logic [21:0] a, off;
    sz = m_q.size();
    idle_old = !m_wr && !m_rest_sd;
    fall = m_dl && !downloading;
    rise = !m_dl && downloading;
    e_busy = (sz != 0) || !idle_old;
    e_done = (m_armed || fall) && sz == 0 && idle_old;
    if (e_done) m_armed = 0; else if (fall) m_armed = 1;
    if (ioctl_wr && sz == 4) e_ovf = 1; else if (rise) e_ovf = 0;
    e_prom_we = 0;
    pop = 0;
    if (m_wr) begin
      if (prog_ack) begin pop = 1; m_wr = 0; m_rest_sd = 1; end
    end else if (m_rest_sd) m_rest_sd = 0;
    else if (m_rest_pr) m_rest_pr = 0;
    else if (sz > 0) begin
      h = m_q[0];
      a = h[29:8];
      if (a < START) begin
        m_wr = 1;
        e_prog_addr = a >> 1;
        e_prog_data = h[7:0];
        e_prog_mask = a[0] ? 2'b01 : 2'b10;
      end else begin
        pop = 1;
        m_rest_pr = 1;
        off = a - START;
        if (int'(off) < PN * 256) begin
          e_prom_we = PN'(1 << (int'(off) / 256));
          e_prom_addr = a[7:0];
          e_prom_data = h[7:0];
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (ioctl_wr && sz < 4) m_q.push_back({ioctl_addr, ioctl_data});
    m_dl = downloading;
    e_prog_we = m_wr;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset(); else model_step();
  end

  // per-cycle compare plus event monitor
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      chk("prog_we", prog_we, e_prog_we);
      if (e_prog_we) begin
        chk("prog_addr", prog_addr, e_prog_addr);
        chk("prog_data", prog_data, e_prog_data);
        chk("prog_mask", prog_mask, e_prog_mask);
      end
      chk("prom_we", prom_we, e_prom_we);
      chk("prom_addr", prom_addr, e_prom_addr);
      chk("prom_data", prom_data, e_prom_data);
      chk("ioctl_wait", ioctl_wait, m_q.size() >= 3);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("ovf", ovf, e_ovf);
      if (prog_we && prog_ack) begin sd_commits++; last_ack_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done_prev) busy_post = busy;
      done_prev = done;
    end
  end

  initial begin
    int hi = 0;
    prog_ack = 0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: prog_ack = 1;
        1: prog_ack = 0;
        2: prog_ack = 1'($urandom_range(0, 1));
        default: begin
          hi = prog_we ? hi + 1 : 0;
          prog_ack = prog_we && hi >= 6;
        end
      endcase
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic put(input logic [21:0] a, input logic [7:0] d);
    ioctl_wr = 1; ioctl_addr = a; ioctl_data = d;
    step();
    ioctl_wr = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    step(); step();
    while ((busy || prog_we) && n < budget) begin step(); n++; end
    repeat (3) step();
    chk("drain_idle", busy, 0);
  endtask

  function automatic logic [21:0] rnd_addr();
    logic [21:0] a;
    case ($urandom_range(0, 3))
      0: a = 22'($urandom_range(0, 15));
      1: a = 22'($urandom_range(0, 'h1DFFFF));
      2: a = START + 22'($urandom_range(0, 'h7FF));
      default: a = START + 22'($urandom_range(0, 'h1FFFF));
    endcase
    return a;
  endfunction

  initial begin
    int c0, i;
    bit wait_seen;
    rst_n = 1; downloading = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_data = 0;
    #2 rst_n = 0;
    #1;
    chk_en = 1;
    chk("rst_prog_we", prog_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_prom_we", prom_we, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    repeat (3) step();
    rst_n = 1;
    downloading = 1;
    step(); step();

    // single SDRAM byte, ack held high
    ack_mode = 0; step();
    put(22'h000005, 8'hA5);
    @(negedge clk); chk("t1_we_n1", prog_we, 0);
    step(); @(negedge clk);
    chk("t1_we_n2", prog_we, 1);
    chk("t1_addr", prog_addr, 22'h000002);
    chk("t1_mask", prog_mask, 2'b01);
    chk("t1_data", prog_data, 8'hA5);
    step(); @(negedge clk); chk("t1_we_n3", prog_we, 0);
    drain(50);

    // burst of 8 with 5-cycle delayed ack
    ack_mode = 3; c0 = sd_commits; wait_seen = 0; i = 0;
    for (int t = 0; t < 80 && i < 8; t++) begin
      if (ioctl_wait) begin wait_seen = 1; ioctl_wr = 0; end
      else begin ioctl_wr = 1; ioctl_addr = 22'(i); ioctl_data = 8'(8'h40 + i); i++; end
      step();
    end
    ioctl_wr = 0;
    drain(300);
    chk("t2_wait_seen", wait_seen, 1);
    chk("t2_commits", sd_commits - c0, 8);
    chk("t2_last_addr", prog_addr, 22'h000003);
    chk("t2_last_mask", prog_mask, 2'b01);
    chk("t2_ovf", ovf, 0);

    // PROM routing
    ack_mode = 0;
    put(START + 22'h312, 8'h3C);
    @(negedge clk); chk("t3_prom_n1", prom_we, 0);
    step(); @(negedge clk);
    chk("t3_prom_we", prom_we, 8'b0000_1000);
    chk("t3_prom_addr", prom_addr, 8'h12);
    chk("t3_prom_data", prom_data, 8'h3C);
    chk("t3_no_prog", prog_we, 0);
    step(); @(negedge clk); chk("t3_prom_n3", prom_we, 0);
    put(START + 22'h800, 8'h5A);
    @(negedge clk); chk("t3_drop_n1", prom_we, 0);
    step(); @(negedge clk); chk("t3_drop_n2", prom_we, 0);
    chk("t3_addr_kept", prom_addr, 8'h12);
    drain(50);

    // overflow with ack tied low
    ack_mode = 1; c0 = sd_commits;
    for (int k = 0; k < 5; k++) begin
      ioctl_wr = 1; ioctl_addr = 22'(16 + k); ioctl_data = 8'(k); step();
    end
    ioctl_wr = 0;
    @(negedge clk);
    chk("t4_ovf", ovf, 1);
    chk("t4_wait", ioctl_wait, 1);
    downloading = 0; step();
    downloading = 1; step();
    @(negedge clk); chk("t4_ovf_clr", ovf, 0);
    ack_mode = 0;
    drain(100);
    chk("t4_retained", sd_commits - c0, 4);

    // completion: downloading falls with 2 bytes pending
    done_cnt = 0; busy_post = 1;
    for (int k = 0; k < 3; k++) begin
      ioctl_wr = 1; ioctl_addr = 22'(32 + k); ioctl_data = 8'(8'hC0 + k); step();
    end
    ioctl_wr = 0; downloading = 0;
    for (int t = 0; t < 100 && done_cnt == 0; t++) step();
    repeat (5) step();
    chk("t5_done_once", done_cnt, 1);
    chk("t5_done_lat", done_cyc - last_ack_cyc, 3);
    chk("t5_busy_post", busy_post, 0);
    downloading = 1; step(); step();

    // reset during SDWR
    ack_mode = 1;
    put(22'h000020, 8'h11);
    step();
    @(negedge clk); chk("t6_we_before", prog_we, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_we", prog_we, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wait", ioctl_wait, 0);
    ack_mode = 0;
    step(); step();
    rst_n = 1;
    step();
    put(22'h000010, 8'h77);
    step(); @(negedge clk);
    chk("t6_we_after", prog_we, 1);
    chk("t6_addr_after", prog_addr, 22'h000008);
    chk("t6_mask_after", prog_mask, 2'b10);
    chk("t6_data_after", prog_data, 8'h77);
    drain(50);

    // random traffic against the model
    ack_mode = 2;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 99) < 3) downloading = ~downloading;
      if ($urandom_range(0, 99) < 60 && (!ioctl_wait || $urandom_range(0, 9) == 0)) begin
        ioctl_wr = 1; ioctl_addr = rnd_addr(); ioctl_data = 8'($urandom);
      end else ioctl_wr = 0;
      step();
    end
    ioctl_wr = 0; downloading = 0; ack_mode = 0;
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
